// File: rtl/ws2812_step_scheduler_if.sv
// Control/handshake bundle between the mode logic, the step scheduler and the WS2812 frame driver.
// master drives enable/pause/mode and the driver's ack/done; slave is the scheduler itself.
interface ws2812_step_scheduler_if;
    logic       enable;
    logic       pause;
    logic [1:0] mode;
    logic       frame_ack;
    logic       frame_done;
    logic [3:0] step_idx;
    logic       frame_req;
    logic       busy;
    logic       seq_done;
    logic       overrun;

    modport master (
        output enable, pause, mode, frame_ack, frame_done,
        input  step_idx, frame_req, busy, seq_done, overrun
    );

    modport slave (
        input  enable, pause, mode, frame_ack, frame_done,
        output step_idx, frame_req, busy, seq_done, overrun
    );
endinterface

// File: rtl/ws2812_step_scheduler.sv
// Steps a WS2812 chain through STEP_MAX patterns, one frame request per STEP_MS tick,
// with loop / one-shot / ping-pong ordering, pause and sticky overrun detection.
module ws2812_step_scheduler #(
    parameter int unsigned CLK_PER_MS = 50_000,
    parameter int unsigned STEP_MS    = 100,
    parameter int unsigned STEP_MAX   = 10
) (
    input logic                    sys_clk,
    input logic                    sys_rst,
    ws2812_step_scheduler_if.slave bus
);

    localparam int unsigned PreW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int unsigned MsW  = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(CLK_PER_MS - 1);
    localparam logic [MsW-1:0]  MsMax  = MsW'(STEP_MS - 1);
    localparam logic [3:0]      IdxMax = 4'(STEP_MAX - 1);

    typedef enum logic [2:0] {StIdle, StReq, StBusy, StWait, StDone} state_e;

    state_e          state_d, state_q;
    logic [PreW-1:0] pre_cnt_d, pre_cnt_q;
    logic [MsW-1:0]  ms_cnt_d, ms_cnt_q;
    logic [3:0]      idx_d, idx_q;
    logic [1:0]      mode_d, mode_q;
    logic            pending_d, pending_q;
    logic            dir_down_d, dir_down_q;
    logic            overrun_d, overrun_q;

    logic            run, ms_tick, step_tick, in_flight;
    logic [3:0]      adv_idx;
    logic            adv_dir_down;

    // Timebase runs only in the active states and freezes while paused.
    always_comb begin
        run       = (state_q == StReq || state_q == StBusy || state_q == StWait) && !bus.pause;
        ms_tick   = run && (pre_cnt_q == PreMax);
        step_tick = ms_tick && (ms_cnt_q == MsMax);
        pre_cnt_d = pre_cnt_q;
        ms_cnt_d  = ms_cnt_q;
        if (state_q == StIdle || state_q == StDone) begin
            pre_cnt_d = '0;
            ms_cnt_d  = '0;
        end else if (run) begin
            pre_cnt_d = ms_tick ? '0 : pre_cnt_q + PreW'(1);
            if (ms_tick) begin
                ms_cnt_d = step_tick ? '0 : ms_cnt_q + MsW'(1);
            end
        end
    end

    always_comb begin
        adv_idx      = idx_q;
        adv_dir_down = dir_down_q;
        case (mode_q)
            2'd1: begin
                if (idx_q != IdxMax) adv_idx = idx_q + 4'd1;
            end
            2'd2: begin
                if (IdxMax != 4'd0) begin
                    if (!dir_down_q) begin
                        if (idx_q == IdxMax) begin
                            adv_dir_down = 1'b1;
                            adv_idx      = idx_q - 4'd1;
                        end else begin
                            adv_idx = idx_q + 4'd1;
                        end
                    end else if (idx_q == 4'd0) begin
                        adv_dir_down = 1'b0;
                        adv_idx      = idx_q + 4'd1;
                    end else begin
                        adv_idx = idx_q - 4'd1;
                    end
                end
            end
            default: adv_idx = (idx_q == IdxMax) ? 4'd0 : idx_q + 4'd1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        pending_d  = pending_q;
        dir_down_d = dir_down_q;
        overrun_d  = overrun_q;
        in_flight  = (state_q == StReq) || (state_q == StBusy);

        if (in_flight && step_tick) begin
            pending_d = 1'b1;
            overrun_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                pending_d = 1'b0;
                if (bus.enable) begin
                    mode_d     = bus.mode;
                    idx_d      = 4'd0;
                    dir_down_d = 1'b0;
                    overrun_d  = 1'b0;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (bus.frame_ack) state_d = StBusy;
            end
            StBusy: begin
                if (bus.frame_done) begin
                    if (mode_q == 2'd1 && idx_q == IdxMax) begin
                        state_d = StDone;
                    end else if (pending_q || step_tick) begin
                        idx_d      = adv_idx;
                        dir_down_d = adv_dir_down;
                        pending_d  = 1'b0;
                        state_d    = StReq;
                    end else if (!bus.enable) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (step_tick) begin
                    idx_d      = adv_idx;
                    dir_down_d = adv_dir_down;
                    state_d    = StReq;
                end
            end
            StDone: begin
                if (!bus.enable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= StIdle;
            pre_cnt_q  <= '0;
            ms_cnt_q   <= '0;
            idx_q      <= 4'd0;
            mode_q     <= 2'd0;
            pending_q  <= 1'b0;
            dir_down_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            pending_q  <= pending_d;
            dir_down_q <= dir_down_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.step_idx  = idx_q;
    assign bus.frame_req = (state_q == StReq);
    assign bus.busy      = (state_q != StIdle);
    assign bus.seq_done  = (state_q == StDone);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_ws2812_step_scheduler.sv
// Scoreboard bench: scenarios push expected (index, spacing) per frame request; a monitor
// pops and compares on every rising frame_req; a driver model answers with ack/done.
module tb_ws2812_step_scheduler;

    localparam int unsigned CPM  = 4;
    localparam int unsigned SMS  = 2;
    localparam int unsigned SMAX = 4;
    localparam int          Period = CPM * SMS;

    typedef struct {
        int idx;
        int gap;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    ws2812_step_scheduler_if bus_if();

    ws2812_step_scheduler #(
        .CLK_PER_MS(CPM),
        .STEP_MS   (SMS),
        .STEP_MAX  (SMAX)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    exp_t exp_q[$];
    int   dly_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    bit   drv_on = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ordering: loop/one-shot count modulo STEP_MAX, ping-pong folds a 2*(N-1) ramp.
    function automatic int model_idx(input int m, input int n);
        int p;
        if (m == 2) begin
            p = n % (2 * SMAX - 2);
            return (p < SMAX) ? p : (2 * SMAX - 2 - p);
        end
        return n % SMAX;
    endfunction

    task automatic push_exp(input int idx, input int gap);
        exp_t e;
        e.idx = idx;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        logic req_prev;
        int   last_rise;
        exp_t e;
        req_prev  = 1'b0;
        last_rise = 0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                req_prev = 1'b0;
            end else begin
                if (bus_if.frame_req && !req_prev) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_req: idx %0d requested, none expected (cycle %0d)",
                                 bus_if.step_idx, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("req_idx", int'(bus_if.step_idx), e.idx);
                        if (e.gap != 0) check("req_gap", cyc - last_rise, e.gap);
                    end
                    last_rise = cyc;
                end
                req_prev = bus_if.frame_req;
            end
        end
    end

    // Driver model: ack 1 cycle after req, done d cycles after ack
    initial begin
        int d;
        bus_if.frame_ack  = 1'b0;
        bus_if.frame_done = 1'b0;
        forever begin
            if (drv_on && bus_if.frame_req && !sys_rst) begin
                d = (dly_q.size() > 0) ? dly_q.pop_front() : int'($urandom_range(1, 4));
                bus_if.frame_ack = 1'b1;
                @(posedge sys_clk);
                #1 bus_if.frame_ack = 1'b0;
                repeat (d - 1) @(posedge sys_clk);
                #1 bus_if.frame_done = 1'b1;
                @(posedge sys_clk);
                #1 bus_if.frame_done = 1'b0;
            end else begin
                @(posedge sys_clk);
                #1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge sys_clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: %0d requests outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        bus_if.enable = 1'b0;
        bus_if.pause  = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (25) @(posedge sys_clk);
        #1;
        dly_q.delete();
    endtask

    task automatic start(input logic [1:0] m);
        @(posedge sys_clk);
        #1 bus_if.mode = m;
        bus_if.enable = 1'b1;
    endtask

    initial begin
        int         n, k;
        logic [1:0] m;
        bus_if.enable = 1'b1;
        bus_if.pause  = 1'b0;
        bus_if.mode   = 2'd2;

        // Reset wins even with enable high
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_frame_req", bus_if.frame_req, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_seq_done", bus_if.seq_done, 0);
        check("rst_overrun", bus_if.overrun, 0);
        check("rst_step_idx", bus_if.step_idx, 0);
        bus_if.enable = 1'b0;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1 drv_on = 1'b1;

        // Loop (mode 0 or 3)
        n = $urandom_range(5, 8);
        m = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
        for (int i = 0; i < n; i++) push_exp(model_idx(0, i), (i == 0) ? 0 : Period);
        start(m);
        @(posedge sys_clk);
        #1 check("loop_req_next_cycle", bus_if.frame_req, 1);
        wait_drain(n * Period + 20, "loop");
        check("loop_overrun", bus_if.overrun, 0);
        do_reset();

        // One-shot
        for (int i = 0; i < SMAX; i++) push_exp(model_idx(1, i), (i == 0) ? 0 : Period);
        start(2'd1);
        wait_drain(SMAX * Period + 20, "oneshot");
        k = 0;
        while (!bus_if.seq_done && k < 20) begin
            @(posedge sys_clk);
            #1 k++;
        end
        repeat (12) @(posedge sys_clk);
        #1;
        check("oneshot_seq_done", bus_if.seq_done, 1);
        check("oneshot_busy", bus_if.busy, 1);
        check("oneshot_step_idx", bus_if.step_idx, SMAX - 1);
        bus_if.enable = 1'b0;
        @(posedge sys_clk);
        #1;
        check("oneshot_exit_seq_done", bus_if.seq_done, 0);
        check("oneshot_exit_busy", bus_if.busy, 0);

        // Ping-pong, finishing with enable dropped in WAIT
        for (int i = 0; i < 8; i++) push_exp(model_idx(2, i), (i == 0) ? 0 : Period);
        start(2'd2);
        wait_drain(8 * Period + 20, "pingpong");
        repeat (5) @(posedge sys_clk);
        #1 bus_if.enable = 1'b0;
        @(posedge sys_clk);
        #1 check("pingpong_wait_exit_busy", bus_if.busy, 0);
        repeat (12) @(posedge sys_clk);
        #1;

        // Overrun: 20-cycle frames force immediate re-requests
        dly_q = '{20, 20, 20};
        push_exp(0, 0);
        push_exp(1, 21);
        push_exp(2, 21);
        start(2'd0);
        wait_drain(100, "overrun");
        check("overrun_set", bus_if.overrun, 1);
        do_reset();
        check("overrun_cleared_by_reset", bus_if.overrun, 0);

        // Pause 30 cycles in WAIT: the step period resumes, not restarts
        dly_q = '{3};
        push_exp(0, 0);
        push_exp(1, Period + 30);
        push_exp(2, Period);
        start(2'd0);
        k = 0;
        while (exp_q.size() == 3 && k < 20) begin
            @(posedge sys_clk);
            k++;
        end
        repeat (5) @(posedge sys_clk);
        #1 bus_if.pause = 1'b1;
        repeat (30) @(posedge sys_clk);
        #1 bus_if.pause = 1'b0;
        wait_drain(80, "pause");
        check("pause_overrun", bus_if.overrun, 0);
        do_reset();

        // Reset mid-frame, then a late frame_done
        drv_on = 1'b0;
        push_exp(0, 0);
        start(2'd0);
        k = 0;
        while (!bus_if.frame_req && k < 5) begin
            @(posedge sys_clk);
            #1 k++;
        end
        check("midrst_req_seen", bus_if.frame_req, 1);
        bus_if.frame_ack = 1'b1;
        @(posedge sys_clk);
        #1 bus_if.frame_ack = 1'b0;
        check("midrst_busy_before", bus_if.busy, 1);
        sys_rst = 1'b1;
        bus_if.enable = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        check("midrst_frame_req", bus_if.frame_req, 0);
        check("midrst_busy", bus_if.busy, 0);
        check("midrst_seq_done", bus_if.seq_done, 0);
        check("midrst_overrun", bus_if.overrun, 0);
        check("midrst_step_idx", bus_if.step_idx, 0);
        bus_if.frame_done = 1'b1;
        @(posedge sys_clk);
        #1 bus_if.frame_done = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("late_done_busy", bus_if.busy, 0);
        check("late_done_frame_req", bus_if.frame_req, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ws2812_step_scheduler.md
Name: ws2812_step_scheduler

Overview:
- Sequences the WS2812 LED chain through a fixed number of pattern steps.
- An internal ms prescaler and step timebase produce a step tick every STEP_MS milliseconds. On each tick the block advances a step index and requests one frame from the WS2812 frame driver over a req/ack/done handshake.
- Supports loop, one-shot and ping-pong step orders, pause, and detection of frames that overrun the step period.
- Sits between the top-level mode/key logic and the WS2812 bit-serial driver.

Parameters:
- CLK_PER_MS, 50_000, sys_clk cycles per ms (50 MHz clock).
- STEP_MS, 100, ms per step; legal range 1..1023.
- STEP_MAX, 10, number of steps; legal range 1..16.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- enable  in  1  level; high runs the sequence, low stops it.
- pause  in  1  level; freezes the timebase only.
- mode  in  2  0 = loop, 1 = one-shot, 2 = ping-pong, 3 = treated as loop; latched on sequence start.
- frame_ack  in  1  1-cycle pulse: driver accepted the request.
- frame_done  in  1  1-cycle pulse: driver finished the frame.
- step_idx  out  4  current step index; stable while frame_req or a frame is in flight.
- frame_req  out  1  level request to the driver.
- busy  out  1  high when state != IDLE.
- seq_done  out  1  one-shot sequence completed.
- overrun  out  1  sticky: a step tick arrived while a frame was in flight.

Behaviour:
- Reset: all outputs 0; state IDLE; prescaler, ms counter, pending, direction (up) and latched mode all cleared. Reset wins over every other input in that cycle.
- Timebase:
  - pre_cnt counts 0..CLK_PER_MS-1. ms_tick = (pre_cnt == CLK_PER_MS-1).
  - ms_cnt advances on ms_tick and wraps at STEP_MS-1. step_tick = ms_tick && (ms_cnt == STEP_MS-1).
  - Counts only when state is not IDLE/DONE and pause = 0. Held when paused. Cleared to 0 in IDLE/DONE.
  - Counter widths come from clog2 of the maxima.
- FSM states: IDLE, REQ, BUSY, WAIT, DONE.
- IDLE:
  - On enable = 1: latch mode, step_idx = 0, dir = up, go to REQ.
  - frame_req rises the cycle after enable is first sampled high.
- REQ:
  - frame_req = 1.
  - On frame_ack: frame_req drops the next cycle, go to BUSY.
  - A frame_ack in any other state is ignored.
- BUSY: on frame_done:
  - If one-shot and step_idx == STEP_MAX-1 -> DONE (seq_done = 1).
  - Else if pending -> advance the index, clear pending, go to REQ.
  - Else if enable = 0 -> IDLE.
  - Else -> WAIT.
- WAIT:
  - On step_tick: advance the index, go to REQ.
  - If enable = 0: go to IDLE.
- DONE: seq_done held at 1 until enable = 0, then IDLE with seq_done = 0.
- Step tick during REQ or BUSY:
  - Sets pending and overrun. Multiple ticks collapse into one pending.
  - The index is not changed until the frame completes.
  - overrun clears only on reset or on an IDLE -> REQ start.
- enable = 0 during REQ or BUSY: the in-flight frame completes, then IDLE. frame_req is never withdrawn before frame_ack.
- Index advance:
  - Loop: step_idx == STEP_MAX-1 -> 0, else +1.
  - Ping-pong:
    - If dir = up and step_idx == STEP_MAX-1, set dir = down and decrement.
    - If dir = down and step_idx == 0, set dir = up and increment.
    - STEP_MAX = 1 keeps step_idx at 0.
  - One-shot: +1 (end handled in BUSY).
- Simultaneous frame_done and step_tick in BUSY: treated as pending (immediate re-request), overrun set.
- pause does not affect the handshake; an in-flight frame still completes.

Test Plan:
All scenarios use CLK_PER_MS = 4 and STEP_MS = 2, so step_tick fires every 8 cycles; STEP_MAX = 4. The driver model returns ack 1 cycle after req and done 3 cycles after ack.
- Loop: raise enable, mode = 0 -> frame_req high the next cycle; step_idx sequence 0,1,2,3,0,1 at 8-cycle spacing; overrun stays 0.
- One-shot: mode = 1 -> frames for 0,1,2,3; after done of step 3, seq_done = 1 and busy stays 1. Drop enable -> IDLE next cycle, seq_done = 0, busy = 0.
- Ping-pong: mode = 2 -> step_idx sequence 0,1,2,3,2,1,0,1.
- Overrun: driver delays done by 20 cycles -> overrun = 1; exactly one re-request for the next index on the cycle after done; the index skips no values.
- Pause: assert pause for 30 cycles in WAIT -> no step_tick; after release, the next req occurs at the remaining count, not restarted.
- Reset mid-frame: assert sys_rst while in BUSY -> next cycle all outputs 0, state IDLE; a late frame_done is ignored.
